// File: rtl/wb_cmd_pkg.sv
// Shared definitions for the host-command to Wishbone formatter:
// FSM encodings and the bit layout of the 32-bit command word.
package wb_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CMD_W       = 32;
  localparam int CMD_WE_BIT  = 31;
  localparam int CMD_ADR_MSB = 30;
  localparam int CMD_ADR_LSB = 24;
  localparam int CMD_DAT_MSB = 15;
  localparam int TMO_CNT_W   = 16;

endpackage

// File: rtl/cmd_fifo.sv
// First-word-fall-through synchronous FIFO holding queued host commands.
// Pushes while full and pops while empty are ignored.
module cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer MSB tells a wrapped (full) queue apart from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_cmd_formatter.sv
// Turns queued 32-bit host command words into single Wishbone classic cycles,
// with an ack timeout, read-data capture and sticky drop/timeout flags.
module wb_cmd_formatter
  import wb_cmd_pkg::*;
#(
  parameter int ADR_W     = 7,
  parameter int DAT_W     = 16,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ep_dataout,
  input  logic             trigger,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [ADR_W-1:0] wb_adr_o,
  output logic [DAT_W-1:0] wb_dat_o,
  input  logic [DAT_W-1:0] wb_dat_i,
  input  logic             wb_ack_i,
  output logic [DAT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             cmd_dropped,
  output logic             wb_timeout
);

  localparam logic [TMO_CNT_W-1:0] CNT_ONE  = TMO_CNT_W'(1);
  localparam logic [TMO_CNT_W-1:0] CNT_LAST = TMO_CNT_W'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [ADR_W-1:0]     adr_q, adr_d;
  logic [DAT_W-1:0]     dat_q, dat_d;
  logic [DAT_W-1:0]     rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 timeout_q, timeout_d;
  logic                 dropped_q;
  logic                 busy_q;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CMD_W-1:0]     fifo_dout;
  logic [7:0]           unused_rsvd;

  assign fifo_push   = trigger && !fifo_full;
  assign unused_rsvd = fifo_dout[23:16];

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (ep_dataout),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    timeout_d  = timeout_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          we_d     = fifo_dout[CMD_WE_BIT];
          adr_d    = fifo_dout[CMD_ADR_LSB +: ADR_W];
          dat_d    = fifo_dout[CMD_DAT_MSB -: DAT_W];
          cyc_d    = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        // Ack wins over a simultaneous expiry of the wait counter.
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            rd_data_d  = wb_dat_i;
            rd_valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          cyc_d     = 1'b0;
          timeout_d = 1'b1;
          cnt_d     = cnt_q + CNT_ONE;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      dropped_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      timeout_q  <= timeout_d;
      dropped_q  <= dropped_q || (trigger && fifo_full);
      busy_q     <= !fifo_empty || (state_q != IDLE);
    end
  end

  // Strobe and cycle are asserted and released together for single transfers.
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign busy        = busy_q;
  assign cmd_dropped = dropped_q;
  assign wb_timeout  = timeout_q;

endmodule
